// File: rtl/mem_fill_responder.sv
// -----------------------------------------------------------------------------
// mem_fill_responder
//
// Memory-side responder for cache line fills. This is a single-port,
// word-organised main memory with a fixed, pipelined read latency. It accepts
// one request per cycle. Read data comes back exactly LATENCY cycles after
// issue, with a one-cycle data_valid strobe. Reads return in issue order, and
// back-to-back reads stream out back-to-back. There is no backpressure.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   - requests with addr[0]=1 are dropped, and the extra output
//               `misaligned` flags them in the request cycle
//   undefined - addr[0] is ignored and misaligned requests are serviced
//
// Ports
//   clk         in   clock, all state on rising edge
//   rst         in   asynchronous active-high reset
//   enable      in   request valid this cycle
//   wr          in   1 = write, 0 = read (qualified by enable)
//   addr        in   byte address, word index = addr[DEPTH_LOG2:1]
//   data_in     in   write data
//   data_out    out  read data; holds last returned word while data_valid=0
//   data_valid  out  read data returned this cycle
//   in_flight   out  reads issued but not yet returned
//   misaligned  out  (MEM_MISALIGN_CHECK_EN only) enable & addr[0]
// -----------------------------------------------------------------------------
module mem_fill_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         wr,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_valid,
    output logic [$clog2(LATENCY+1)-1:0] in_flight
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                         misaligned
`endif
);

    localparam int IFW   = $clog2(LATENCY+1);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic [DATA_W-1:0]     rdWord;
    logic                  dropReq;
    logic                  doWrite;
    logic                  doRead;
    logic [LATENCY-1:0]    vldPipe;
    logic [DATA_W-1:0]     datPipe [LATENCY];
    logic [IFW-1:0]        inFlightQ;

    assign wordIdx = addr[DEPTH_LOG2:1];

`ifdef MEM_MISALIGN_CHECK_EN
    assign dropReq    = enable & addr[0];
    assign misaligned = enable & addr[0] & ~rst;
`else
    logic unusedAddrLsb;
    assign dropReq       = 1'b0;
    assign unusedAddrLsb = addr[0];
`endif

    // Address bits above the storage index alias onto the same words.
    generate
        if (ADDR_W > DEPTH_LOG2 + 1) begin : g_alias
            logic unusedAddrHigh;
            assign unusedAddrHigh = ^addr[ADDR_W-1:DEPTH_LOG2+1];
        end
    endgenerate

    assign doWrite = enable & wr & ~dropReq;
    assign doRead  = enable & ~wr & ~dropReq;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wordIdx] <= data_in;
        end
    end

    assign rdWord = mem[wordIdx];

    // The word is captured at issue, so a later write to the same address
    // cannot change a read that is already in flight. Each data stage loads
    // only when a valid word enters it. As a result, the last stage naturally
    // holds the most recently returned word while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vldPipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                datPipe[i] <= '0;
            end
        end else begin
            vldPipe[0] <= doRead;
            if (doRead) begin
                datPipe[0] <= rdWord;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vldPipe[i] <= vldPipe[i-1];
                if (vldPipe[i-1]) begin
                    datPipe[i] <= datPipe[i-1];
                end
            end
        end
    end

    assign data_valid = vldPipe[LATENCY-1];
    assign data_out   = datPipe[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inFlightQ <= '0;
        end else begin
            case ({doRead, data_valid})
                2'b10:   inFlightQ <= inFlightQ + IFW'(1);
                2'b01:   inFlightQ <= inFlightQ - IFW'(1);
                default: inFlightQ <= inFlightQ;
            endcase
        end
    end

    assign in_flight = inFlightQ;

endmodule

// File: tb/tb_mem_fill_responder.sv
module tb_mem_fill_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        dataValid;
    logic [2:0]  inFlight;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int   nAssert = 0;
    int   nFail   = 0;
    int   cyc     = 0;
    int   peak    = 0;
    exp_t sbQ[$];
    vec_t vecs[20];

    mem_fill_responder #(
        .ADDR_W(16), .DATA_W(16), .LATENCY(LAT), .DEPTH_LOG2(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wr(wr),
        .addr(addr),
        .data_in(dataIn),
        .data_out(dataOut),
        .data_valid(dataValid),
        .in_flight(inFlight)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misaligned(misaligned)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop and compare every returned word, and its arrival cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(inFlight) > peak) peak = int'(inFlight);
            if (dataValid) begin
                if (sbQ.size() == 0) begin
                    check("unexpected_valid", {31'd0, dataValid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    check("rd_data", {16'd0, dataOut}, {16'd0, e.data});
                    check("rd_time", cyc, e.due);
                end
            end else if (sbQ.size() > 0 && sbQ[0].due < cyc) begin
                exp_t e;
                e = sbQ.pop_front();
                check("missed_return", cyc, e.due);
            end
        end
    end

    task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        enable = 1'b1;
        wr     = w;
        addr   = a;
        dataIn = d;
        if (!w) begin
            x.data = e;
            x.due  = cyc + LAT;
            sbQ.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            enable = 1'b0;
            wr     = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i]   = '{1'b1, 16'h0040 + 16'(2*i), 16'h1000 + 16'(i), 16'h0000};
            vecs[8+i] = '{1'b0, 16'h0040 + 16'(2*i), 16'h0000, 16'h1000 + 16'(i)};
        end
        vecs[16] = '{1'b1, 16'hFFFE, 16'hA5A5, 16'h0000};
        vecs[17] = '{1'b1, 16'h0002, 16'h0F0F, 16'h0000};
        vecs[18] = '{1'b0, 16'hFFFE, 16'h0000, 16'hA5A5};
        vecs[19] = '{1'b0, 16'h0002, 16'h0000, 16'h0F0F};

        rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; dataIn = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, dataValid}, 32'd0);
        check("rst_dout", {16'd0, dataOut}, 32'd0);
        check("rst_inflight", {29'd0, inFlight}, 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
        enable = 1'b1; addr = 16'h0001;
        #1;
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        enable = 1'b0; addr = '0;
`endif
        #1 rst = 1'b0;

        // 1. Reset held mid-stream of 3 reads
        req(1'b1, 16'h0000, 16'h1234, 16'h0);
        req(1'b0, 16'h0000, 16'h0, 16'h1234);
        req(1'b0, 16'h0000, 16'h0, 16'h1234);
        req(1'b0, 16'h0000, 16'h0, 16'h1234);
        @(posedge clk);
        #1;
        rst = 1'b1; enable = 1'b0; wr = 1'b0;
        sbQ.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2*LAT; i++) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, dataValid}, 32'd0);
            check("post_rst_inflight", {29'd0, inFlight}, 32'd0);
        end

        // 2. Single read after write; then data_out holds
        req(1'b1, 16'h0010, 16'hBEEF, 16'h0);
        req(1'b0, 16'h0010, 16'h0, 16'hBEEF);
        idle(LAT + 2);
        check("hold_dout", {16'd0, dataOut}, 32'h0000BEEF);
        check("hold_valid", {31'd0, dataValid}, 32'd0);

        // 3. Table: line fill and edge addresses
        peak = 0;
        for (int i = 0; i < 20; i++) begin
            req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e);
        end
        idle(LAT + 2);
        check("fill_peak", peak, LAT);
        check("fill_inflight_end", {29'd0, inFlight}, 32'd0);

        // 4. Write-after-read, then re-read
        req(1'b1, 16'h0020, 16'h1111, 16'h0);
        idle(1);
        req(1'b0, 16'h0020, 16'h0, 16'h1111);
        req(1'b1, 16'h0020, 16'h2222, 16'h0);
        req(1'b0, 16'h0020, 16'h0, 16'h2222);
        idle(LAT + 2);

        // 5. Misaligned request
`ifdef MEM_MISALIGN_CHECK_EN
        @(posedge clk);
        #1;
        enable = 1'b1; wr = 1'b0; addr = 16'h0011;
        #1;
        check("mis_read_flag", {31'd0, misaligned}, 32'd1);
        @(posedge clk);
        #1;
        check("mis_read_inflight", {29'd0, inFlight}, 32'd0);
        wr = 1'b1; dataIn = 16'hDEAD;
        #1;
        check("mis_write_flag", {31'd0, misaligned}, 32'd1);
        req(1'b0, 16'h0010, 16'h0, 16'hBEEF);
        idle(LAT + 2);
        check("mis_flag_idle", {31'd0, misaligned}, 32'd0);
        check("mis_inflight_end", {29'd0, inFlight}, 32'd0);
`else
        req(1'b0, 16'h0011, 16'h0, 16'hBEEF);
        idle(LAT + 2);
`endif

        // 6. Async reset between edges while a word is returning
        req(1'b1, 16'h0030, 16'h5A5A, 16'h0);
        for (int i = 0; i < 4; i++) req(1'b0, 16'h0030, 16'h0, 16'h5A5A);
        @(posedge clk);
        #1;
        enable = 1'b0; wr = 1'b0;
        #1;
        check("pre_arst_valid", {31'd0, dataValid}, 32'd1);
        check("pre_arst_inflight", {29'd0, inFlight}, 32'd4);
        rst = 1'b1;
        sbQ.delete();
        #1;
        check("arst_valid", {31'd0, dataValid}, 32'd0);
        check("arst_inflight", {29'd0, inFlight}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req(1'b0, 16'h0030, 16'h0, 16'h5A5A);
        idle(LAT + 2);

        check("sb_empty", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
